// File: rtl/alu_control_decoder_if.sv
// Request/response bundle between the main control unit and the ALU control decoder.
interface alu_control_decoder_if;
  logic       in_valid;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [2:0] aluCtrl;
  logic       out_valid;
  logic       illegal;

  modport master (
    output in_valid, aluop, funct,
    input  aluCtrl, out_valid, illegal
  );

  modport slave (
    input  in_valid, aluop, funct,
    output aluCtrl, out_valid, illegal
  );
endinterface

// File: rtl/alu_control_decoder.sv
// Registered ALU control decoder: (aluop, funct) -> 3-bit ALU control code.
// Define ALUDEC_EXT_OPS_EN to make the xor/nor R-type functs legal.
module alu_control_decoder #(
  parameter logic [2:0] DEFAULT_CTRL = 3'b010
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_control_decoder_if.slave  bus
);

  logic [2:0] w_ctrl;
  logic       w_illegal;
  logic [2:0] r_alu_ctrl;
  logic       r_out_valid;
  logic       r_illegal;

  // Combinational decode; aluop[1] selects R-type regardless of aluop[0].
  always_comb begin
    w_ctrl    = DEFAULT_CTRL;
    w_illegal = 1'b0;
    if (bus.aluop[1]) begin
      case (bus.funct)
        6'b100000: w_ctrl = 3'b010;
        6'b100010: w_ctrl = 3'b110;
        6'b100100: w_ctrl = 3'b000;
        6'b100101: w_ctrl = 3'b001;
        6'b101010: w_ctrl = 3'b111;
`ifdef ALUDEC_EXT_OPS_EN
        6'b100110: w_ctrl = 3'b100;
        6'b100111: w_ctrl = 3'b101;
`endif
        default: begin
          w_ctrl    = DEFAULT_CTRL;
          w_illegal = 1'b1;
        end
      endcase
    end else if (bus.aluop[0]) begin
      w_ctrl = 3'b110;
    end else begin
      w_ctrl = 3'b010;
    end
  end

  // Output register; code and illegal flag hold when no input is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_ctrl  <= DEFAULT_CTRL;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.in_valid) begin
      r_alu_ctrl  <= w_ctrl;
      r_out_valid <= 1'b1;
      r_illegal   <= w_illegal;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.aluCtrl   = r_alu_ctrl;
  assign bus.out_valid = r_out_valid;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_control_decoder.sv
// Directed self-checking bench for alu_control_decoder (honours ALUDEC_EXT_OPS_EN).
module tb_alu_control_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_control_decoder_if bus_if ();

  alu_control_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input vector, clock it in, and settle just past the edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn);
    bus_if.in_valid = v;
    bus_if.aluop    = op;
    bus_if.funct    = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 2'b00, 6'd0);
    step(1'b0, 2'b00, 6'd0);
    checks++;
    if (bus_if.aluCtrl !== 3'b010 || bus_if.out_valid !== 1'b0 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ctrl=%b v=%b ill=%b expected ctrl=010 v=0 ill=0",
               bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal);
    end
    step(1'b1, 2'b10, 6'd0);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_valid: got v=%b ill=%b expected v=0 ill=0",
               bus_if.out_valid, bus_if.illegal);
    end
    reset = 1'b0;
  endtask

  task automatic test_non_rtype();
    logic [1:0] ops  [3] = '{2'b00, 2'b01, 2'b00};
    logic [5:0] fns  [3] = '{6'd32, 6'd34, 6'd0};
    logic [2:0] exps [3] = '{3'b010, 3'b110, 3'b010};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ops[i], fns[i]);
      checks++;
      if (bus_if.aluCtrl !== exps[i] || bus_if.out_valid !== 1'b1 || bus_if.illegal !== 1'b0) begin
        errors++;
        $display("FAIL non_rtype[%0d]: got ctrl=%b v=%b ill=%b expected ctrl=%b v=1 ill=0",
                 i, bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fns  [5] = '{6'd36, 6'd32, 6'd34, 6'd37, 6'd42};
    logic [2:0] exps [5] = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b111};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b10, fns[i]);
      checks++;
      if (bus_if.aluCtrl !== exps[i] || bus_if.out_valid !== 1'b1 || bus_if.illegal !== 1'b0) begin
        errors++;
        $display("FAIL rtype_b2b[%0d]: got ctrl=%b v=%b ill=%b expected ctrl=%b v=1 ill=0",
                 i, bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal, exps[i]);
      end
    end
  endtask

  task automatic test_aluop11();
    step(1'b1, 2'b11, 6'd37);
    checks++;
    if (bus_if.aluCtrl !== 3'b001 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL aluop11_or: got ctrl=%b ill=%b expected ctrl=001 ill=0",
               bus_if.aluCtrl, bus_if.illegal);
    end
    step(1'b1, 2'b11, 6'd34);
    checks++;
    if (bus_if.aluCtrl !== 3'b110 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL aluop11_sub: got ctrl=%b ill=%b expected ctrl=110 ill=0",
               bus_if.aluCtrl, bus_if.illegal);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 2'b10, 6'd0);
    checks++;
    if (bus_if.aluCtrl !== 3'b010 || bus_if.illegal !== 1'b1 || bus_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal_funct: got ctrl=%b v=%b ill=%b expected ctrl=010 v=1 ill=1",
               bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal);
    end
    step(1'b1, 2'b01, 6'd0);
    checks++;
    if (bus_if.aluCtrl !== 3'b110 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got ctrl=%b ill=%b expected ctrl=110 ill=0",
               bus_if.aluCtrl, bus_if.illegal);
    end
    step(1'b1, 2'b10, 6'd63);
    checks++;
    if (bus_if.aluCtrl !== 3'b010 || bus_if.illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_funct63: got ctrl=%b ill=%b expected ctrl=010 ill=1",
               bus_if.aluCtrl, bus_if.illegal);
    end
  endtask

  task automatic test_ext_ops();
    logic [5:0] fns  [2] = '{6'd38, 6'd39};
`ifdef ALUDEC_EXT_OPS_EN
    logic [2:0] exps [2] = '{3'b100, 3'b101};
    logic       ill      = 1'b0;
`else
    logic [2:0] exps [2] = '{3'b010, 3'b010};
    logic       ill      = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'b10, fns[i]);
      checks++;
      if (bus_if.aluCtrl !== exps[i] || bus_if.illegal !== ill) begin
        errors++;
        $display("FAIL ext_op[%0d]: got ctrl=%b ill=%b expected ctrl=%b ill=%b",
                 i, bus_if.aluCtrl, bus_if.illegal, exps[i], ill);
      end
    end
    step(1'b1, 2'b10, 6'd42);
    step(1'b0, 2'b01, 6'd32);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.aluCtrl !== 3'b111 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got ctrl=%b v=%b ill=%b expected ctrl=111 v=0 ill=0",
               bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal);
    end
    step(1'b1, 2'b10, 6'd1);
    step(1'b0, 2'b00, 6'd0);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.aluCtrl !== 3'b010 || bus_if.illegal !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold_illegal: got ctrl=%b v=%b ill=%b expected ctrl=010 v=0 ill=1",
               bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal);
    end
  endtask

  task automatic test_reset_mid_run();
    step(1'b1, 2'b01, 6'd0);
    reset = 1'b1;
    step(1'b1, 2'b10, 6'd42);
    checks++;
    if (bus_if.aluCtrl !== 3'b010 || bus_if.out_valid !== 1'b0 || bus_if.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got ctrl=%b v=%b ill=%b expected ctrl=010 v=0 ill=0",
               bus_if.aluCtrl, bus_if.out_valid, bus_if.illegal);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.aluop    = 2'b00;
    bus_if.funct    = 6'd0;
    test_reset();
    test_non_rtype();
    test_back_to_back();
    test_aluop11();
    test_illegal();
    test_ext_ops();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_control_decoder.md
Name: alu_control_decoder

Overview:
- Main ALU control decoder for the single-cycle/pipelined MIPS-style datapath.
- Sits between the main control unit and the ALU. It maps the 2-bit ALU operation class from the main decoder, plus the R-type funct field, onto the 3-bit ALU control code.
- Output is registered: one-cycle latency, with a valid flag and an illegal-funct flag.

Parameters:
- DEFAULT_CTRL, 3'b010, aluCtrl value driven after reset and on an illegal funct (add).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  aluop/funct are meaningful this cycle.
- aluop  input  2  operation class from the main decoder.
- funct  input  6  instruction bits [5:0] (R-type function field).
- aluCtrl  output  3  ALU control code (registered).
- out_valid  output  1  aluCtrl/illegal correspond to an accepted input.
- illegal  output  1  accepted R-type funct was not decodable.

Behaviour:
- Reset (synchronous, active-high): sampled at a rising clk edge with reset=1.
  - aluCtrl <= DEFAULT_CTRL (3'b010); out_valid <= 0; illegal <= 0.
  - Reset overrides in_valid in the same cycle.
- Latency: an input accepted at edge N (in_valid=1) is visible on the outputs after edge N.
- Every edge with in_valid=1: out_valid <= 1; aluCtrl and illegal <= decode(aluop, funct).
- Every edge with in_valid=0: out_valid <= 0; aluCtrl and illegal hold their previous values.
- Decode, by aluop:
  - 2'b00 (load/store/addi): aluCtrl=3'b010 (add); funct ignored; illegal=0.
  - 2'b01 (beq): aluCtrl=3'b110 (subtract); funct ignored; illegal=0.
  - 2'b10 or 2'b11 (R-type; aluop[1]=1 dominates): decode funct as below.
- R-type funct decode:
  - 6'b100000 (32, add) -> 3'b010
  - 6'b100010 (34, sub) -> 3'b110
  - 6'b100100 (36, and) -> 3'b000
  - 6'b100101 (37, or) -> 3'b001
  - 6'b101010 (42, slt) -> 3'b111
  - Any other funct -> aluCtrl=DEFAULT_CTRL, illegal=1.
- Decode logic is purely combinational ahead of the output register. No X is ever produced on the outputs.
- Back-to-back inputs on consecutive cycles are accepted every cycle; there is no backpressure.

Optional Feature:
- Macro ALUDEC_EXT_OPS_EN.
- When defined, two more R-type functs decode as legal:
  - 6'b100110 (38, xor) -> 3'b100
  - 6'b100111 (39, nor) -> 3'b101
- When not defined, these functs are illegal: aluCtrl=DEFAULT_CTRL, illegal=1.
- All other behaviour is identical in both builds.

Test Plan:
- Reset held 2 cycles, in_valid=0 -> aluCtrl=3'b010, out_valid=0, illegal=0; a later edge with reset=1 and in_valid=1 still gives out_valid=0.
- aluop=00, funct=32 -> aluCtrl=010 one cycle later. Then aluop=01, funct=34 -> 110. Then aluop=00, funct=0 -> 010. illegal=0 throughout.
- aluop=10 with funct=36/32/34/37/42 on consecutive cycles -> aluCtrl=000/010/110/001/111 each one cycle later, out_valid=1 continuously.
- aluop=11, funct=37 -> aluCtrl=001 (aluop=11 decodes as R-type).
- aluop=10, funct=0 -> aluCtrl=010, illegal=1. Next cycle aluop=01 -> illegal=0, aluCtrl=110.
- aluop=10, funct=38 then 39 -> with ALUDEC_EXT_OPS_EN: 100, then 101, illegal=0; without it: 010 with illegal=1. Then in_valid=0 -> out_valid=0, aluCtrl holds.
